// File: rtl/hazard_fwd_ctrl.sv
// rtl/hazard_fwd_ctrl.sv - ID/EX decode, forwarding select and load-use hazard controller
module hazard_fwd_ctrl #(
  parameter int AW       = 5,
  parameter int STAGES   = 3,
  parameter int LOAD_LAT = 1,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      id_ir,
  input  logic             id_valid,
  input  logic             flush,
  output logic             stall,
  output logic [AW-1:0]    ra,
  output logic [AW-1:0]    rb,
  output logic [2:0]       fwd_a,
  output logic [2:0]       fwd_b,
  output logic             ex_valid,
  output logic [3:0]       ex_aluop,
  output logic             ex_dmload,
  output logic             ex_dmstr,
  output logic             ex_dmsel,
  output logic [15:0]      ex_imm,
  output logic [AW-1:0]    ex_dst,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  logic [5:0]    op, funct;
  logic [AW-1:0] rs, rt, rd;
  logic          is_r, is_sys, use_a, use_b;
  logic          dec_load, dec_str;
  logic [AW-1:0] dec_dst;
  logic [3:0]    dec_aluop;
  logic          a_load, b_load, issue;

  // tracking pipeline, index 1 = EX
  logic [STAGES:1] pv, pl;
  logic [AW-1:0]   pd [1:STAGES];

  assign op     = id_ir[31:26];
  assign rs     = id_ir[21 +: AW];
  assign rt     = id_ir[16 +: AW];
  assign rd     = id_ir[11 +: AW];
  assign funct  = id_ir[5:0];
  assign is_r   = (op == 6'h00);
  assign is_sys = is_r && (funct == 6'h0C);
  assign use_a  = !(op == 6'h02 || op == 6'h03);
  assign use_b  = is_r || op == 6'h04 || op == 6'h05 || op == 6'h2B;
  assign ra     = is_sys ? AW'(2) : rs;
  assign rb     = is_sys ? AW'(4) : rt;
  assign dec_load = (op == 6'h23) || (op == 6'h24);
  assign dec_str  = (op == 6'h2B);

  // destination register decode; zero means no write
  always_comb begin
    dec_dst = '0;
    if (is_r) begin
      if (!is_sys) dec_dst = rd;
    end else begin
      case (op)
        6'h08, 6'h09, 6'h0A, 6'h0C, 6'h0D, 6'h0E, 6'h23, 6'h24: dec_dst = rt;
        6'h03:   dec_dst = AW'(31);
        default: dec_dst = '0;
      endcase
    end
  end

  // ALU opcode decode: by funct for R-type, by opcode otherwise
  always_comb begin
    dec_aluop = 4'h0;
    if (is_r) begin
      case (funct)
        6'h02, 6'h06:  dec_aluop = 4'h2;
        6'h03:         dec_aluop = 4'h1;
        6'h20, 6'h21:  dec_aluop = 4'h5;
        6'h22:         dec_aluop = 4'h6;
        6'h24:         dec_aluop = 4'h7;
        6'h25:         dec_aluop = 4'h8;
        6'h26:         dec_aluop = 4'h9;
        6'h27:         dec_aluop = 4'hA;
        6'h2A:         dec_aluop = 4'hB;
        6'h2B:         dec_aluop = 4'hC;
        default:       dec_aluop = 4'h0;
      endcase
    end else begin
      case (op)
        6'h01, 6'h0A:  dec_aluop = 4'hB;
        6'h04, 6'h05:  dec_aluop = 4'h9;
        6'h08, 6'h09:  dec_aluop = 4'h5;
        6'h0C:         dec_aluop = 4'h7;
        6'h0D:         dec_aluop = 4'h8;
        6'h0E:         dec_aluop = 4'h9;
        6'h2B:         dec_aluop = 4'h5;
        default:       dec_aluop = 4'h0;
      endcase
    end
  end

  // youngest matching stage wins: scan oldest to youngest so the last hit is the smallest k
  always_comb begin
    fwd_a  = 3'd0;
    fwd_b  = 3'd0;
    a_load = 1'b0;
    b_load = 1'b0;
    for (int k = STAGES; k >= 1; k--) begin
      if (use_a && pv[k] && pd[k] != '0 && pd[k] == ra) begin
        fwd_a  = 3'(k);
        a_load = pl[k];
      end
      if (use_b && pv[k] && pd[k] != '0 && pd[k] == rb) begin
        fwd_b  = 3'(k);
        b_load = pl[k];
      end
    end
  end

  // a load whose data is not yet forwardable holds ID; a redirect overrides the hold
  always_comb begin
    stall = id_valid && !flush &&
            ((a_load && fwd_a <= 3'(LOAD_LAT)) || (b_load && fwd_b <= 3'(LOAD_LAT)));
    issue = id_valid && !stall && !flush;
  end

  assign ex_valid  = pv[1];
  assign ex_dst    = pd[1];
  assign ex_dmload = pl[1];

  // advance the tracking pipeline; EX receives the ID instruction or a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pv        <= '0;
      pl        <= '0;
      for (int k = 1; k <= STAGES; k++) pd[k] <= '0;
      ex_aluop  <= 4'h0;
      ex_dmstr  <= 1'b0;
      ex_dmsel  <= 1'b0;
      ex_imm    <= 16'h0;
    end else begin
      pv[1]     <= issue;
      pd[1]     <= issue ? dec_dst : '0;
      pl[1]     <= issue && dec_load;
      for (int k = 2; k <= STAGES; k++) begin
        pv[k] <= pv[k-1];
        pd[k] <= pd[k-1];
        pl[k] <= pl[k-1];
      end
      ex_aluop  <= issue ? dec_aluop : 4'h0;
      ex_dmstr  <= issue && dec_str;
      ex_dmsel  <= issue && (dec_load || dec_str);
      ex_imm    <= issue ? id_ir[15:0] : 16'h0;
    end
  end

  // saturating stall/flush event counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall && stall_cnt != {CNT_W{1'b1}}) stall_cnt <= stall_cnt + 1'b1;
      if (flush && flush_cnt != {CNT_W{1'b1}}) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// tb/tb_hazard_fwd_ctrl.sv - table-driven bench for hazard_fwd_ctrl
module tb_hazard_fwd_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] id_ir;
  logic        id_valid, flush;

  logic        stall, ex_valid, ex_dmload, ex_dmstr, ex_dmsel;
  logic [4:0]  ra, rb, ex_dst;
  logic [2:0]  fwd_a, fwd_b;
  logic [3:0]  ex_aluop;
  logic [15:0] ex_imm, stall_cnt, flush_cnt;

  logic        s_stall, s_ex_valid, s_ex_dmload, s_ex_dmstr, s_ex_dmsel;
  logic [4:0]  s_ra, s_rb, s_ex_dst;
  logic [2:0]  s_fwd_a, s_fwd_b;
  logic [3:0]  s_ex_aluop;
  logic [15:0] s_ex_imm;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  hazard_fwd_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_ir(id_ir), .id_valid(id_valid), .flush(flush),
    .stall(stall), .ra(ra), .rb(rb), .fwd_a(fwd_a), .fwd_b(fwd_b),
    .ex_valid(ex_valid), .ex_aluop(ex_aluop), .ex_dmload(ex_dmload), .ex_dmstr(ex_dmstr),
    .ex_dmsel(ex_dmsel), .ex_imm(ex_imm), .ex_dst(ex_dst),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  hazard_fwd_ctrl #(.CNT_W(2)) dut_s (
    .clk(clk), .rst_n(rst_n), .id_ir(id_ir), .id_valid(id_valid), .flush(flush),
    .stall(s_stall), .ra(s_ra), .rb(s_rb), .fwd_a(s_fwd_a), .fwd_b(s_fwd_b),
    .ex_valid(s_ex_valid), .ex_aluop(s_ex_aluop), .ex_dmload(s_ex_dmload), .ex_dmstr(s_ex_dmstr),
    .ex_dmsel(s_ex_dmsel), .ex_imm(s_ex_imm), .ex_dst(s_ex_dst),
    .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  typedef struct {
    logic [31:0] ir;
    logic        v, fl;
    logic        stl, chkf;
    logic [2:0]  fa, fb;
    logic [4:0]  ra, rb;
    logic        exv;
    logic [3:0]  aop;
    logic [4:0]  dst;
    logic [2:0]  mem;   // {load, store, dmsel}
    int          sc, fc;
  } vec_t;

  vec_t tv [16];

  function automatic logic [31:0] rtype(input int s, input int t, input int d, input int f);
    return {6'h00, 5'(s), 5'(t), 5'(d), 5'h00, 6'(f)};
  endfunction

  function automatic logic [31:0] itype(input int o, input int s, input int t, input int imm);
    return {6'(o), 5'(s), 5'(t), 16'(imm)};
  endfunction

  function automatic vec_t mk(input logic [31:0] ir, input logic v, input logic fl,
                              input logic stl, input logic chkf, input int fa, input int fb,
                              input int a, input int b, input logic exv, input int aop,
                              input int dst, input logic [2:0] mem, input int sc, input int fc);
    vec_t r;
    r.ir = ir; r.v = v; r.fl = fl; r.stl = stl; r.chkf = chkf;
    r.fa = 3'(fa); r.fb = 3'(fb); r.ra = 5'(a); r.rb = 5'(b);
    r.exv = exv; r.aop = 4'(aop); r.dst = 5'(dst); r.mem = mem; r.sc = sc; r.fc = fc;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic [31:0] ir, input logic v, input logic fl);
    id_ir = ir; id_valid = v; flush = fl;
    @(posedge clk); #1;
  endtask

  initial begin
    // ir, v, fl, stall, chkfwd, fa, fb, ra, rb, exv, aluop, dst, mem, stall_cnt, flush_cnt
    tv[0]  = mk(rtype(1,2,3,'h20),    1,0, 0,1, 0,0,  1, 2, 1,5, 3, 3'b000, 0,0);
    tv[1]  = mk(rtype(3,4,5,'h22),    1,0, 0,1, 1,0,  3, 4, 1,6, 5, 3'b000, 0,0);
    tv[2]  = mk(itype('h23,1,8,0),    1,0, 0,1, 0,0,  1, 8, 1,0, 8, 3'b101, 0,0);
    tv[3]  = mk(rtype(8,8,9,'h20),    1,0, 1,0, 0,0,  8, 8, 0,0, 0, 3'b000, 1,0);
    tv[4]  = mk(rtype(8,8,9,'h20),    1,0, 0,1, 2,2,  8, 8, 1,5, 9, 3'b000, 1,0);
    tv[5]  = mk(itype('h08,0,7,1),    1,0, 0,1, 0,0,  0, 7, 1,5, 7, 3'b000, 1,0);
    tv[6]  = mk(itype('h0D,0,7,2),    1,0, 0,1, 0,0,  0, 7, 1,8, 7, 3'b000, 1,0);
    tv[7]  = mk(32'h0,                0,0, 0,1, 0,0,  0, 0, 0,0, 0, 3'b000, 1,0);
    tv[8]  = mk(rtype(7,0,10,'h20),   1,0, 0,1, 2,0,  7, 0, 1,5,10, 3'b000, 1,0);
    tv[9]  = mk(rtype(1,1,0,'h20),    1,0, 0,1, 0,0,  1, 1, 1,5, 0, 3'b000, 1,0);
    tv[10] = mk(rtype(0,0,11,'h20),   1,0, 0,1, 0,0,  0, 0, 1,5,11, 3'b000, 1,0);
    tv[11] = mk(itype('h23,1,12,0),   1,0, 0,1, 0,0,  1,12, 1,0,12, 3'b101, 1,0);
    tv[12] = mk(rtype(12,0,13,'h20),  1,1, 0,1, 1,0, 12, 0, 0,0, 0, 3'b000, 1,1);
    tv[13] = mk(itype('h08,0,4,5),    1,0, 0,1, 0,0,  0, 4, 1,5, 4, 3'b000, 1,1);
    tv[14] = mk(32'h0000000C,         1,0, 0,1, 0,1,  2, 4, 1,0, 0, 3'b000, 1,1);
    tv[15] = mk(itype('h2B,4,5,4),    1,0, 0,1, 2,0,  4, 5, 1,5, 0, 3'b011, 1,1);

    // reset state
    rst_n = 1'b0; id_ir = rtype(1,2,3,'h20); id_valid = 1'b1; flush = 1'b0;
    #2;
    chk("rst ex_valid", 32'(ex_valid), 0);
    chk("rst ex_aluop", 32'(ex_aluop), 0);
    chk("rst ex_dst", 32'(ex_dst), 0);
    chk("rst stall_cnt", 32'(stall_cnt), 0);
    chk("rst stall", 32'(stall), 0);
    chk("rst fwd_a", 32'(fwd_a), 0);
    chk("rst ra", 32'(ra), 1);
    @(posedge clk); #1;
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      id_ir = tv[i].ir; id_valid = tv[i].v; flush = tv[i].fl;
      #3;
      chk($sformatf("v%0d stall", i), 32'(stall), 32'(tv[i].stl));
      if (tv[i].chkf) begin
        chk($sformatf("v%0d fwd_a", i), 32'(fwd_a), 32'(tv[i].fa));
        chk($sformatf("v%0d fwd_b", i), 32'(fwd_b), 32'(tv[i].fb));
      end
      chk($sformatf("v%0d ra", i), 32'(ra), 32'(tv[i].ra));
      chk($sformatf("v%0d rb", i), 32'(rb), 32'(tv[i].rb));
      @(posedge clk); #1;
      chk($sformatf("v%0d ex_valid", i), 32'(ex_valid), 32'(tv[i].exv));
      chk($sformatf("v%0d ex_aluop", i), 32'(ex_aluop), 32'(tv[i].aop));
      chk($sformatf("v%0d ex_dst", i), 32'(ex_dst), 32'(tv[i].dst));
      chk($sformatf("v%0d ex_mem", i), 32'({ex_dmload, ex_dmstr, ex_dmsel}), 32'(tv[i].mem));
      chk($sformatf("v%0d ex_imm", i), 32'(ex_imm), tv[i].exv ? 32'(tv[i].ir[15:0]) : 32'h0);
      chk($sformatf("v%0d stall_cnt", i), 32'(stall_cnt), 32'(tv[i].sc));
      chk($sformatf("v%0d flush_cnt", i), 32'(flush_cnt), 32'(tv[i].fc));
    end

    // async reset asserted while a load-use stall is active
    drive(itype('h23,1,8,0), 1'b1, 1'b0);
    id_ir = rtype(8,8,9,'h20);
    #3;
    chk("pre-rst stall", 32'(stall), 1);
    rst_n = 1'b0;
    #1;
    chk("mid-rst stall", 32'(stall), 0);
    chk("mid-rst ex_valid", 32'(ex_valid), 0);
    chk("mid-rst ex_dmload", 32'(ex_dmload), 0);
    chk("mid-rst ex_aluop", 32'(ex_aluop), 0);
    chk("mid-rst ex_dst", 32'(ex_dst), 0);
    chk("mid-rst stall_cnt", 32'(stall_cnt), 0);
    chk("mid-rst flush_cnt", 32'(flush_cnt), 0);
    chk("mid-rst s_stall_cnt", 32'(s_stall_cnt), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    #3;
    chk("post-rst stall", 32'(stall), 0);
    chk("post-rst fwd_a", 32'(fwd_a), 0);
    chk("post-rst fwd_b", 32'(fwd_b), 0);
    @(posedge clk); #1;
    chk("post-rst ex_valid", 32'(ex_valid), 1);
    chk("post-rst ex_dst", 32'(ex_dst), 9);

    // five load-use stalls: 16-bit counter reaches 5, 2-bit counter saturates at 3
    for (int i = 0; i < 5; i++) begin
      drive(itype('h23,1,8,0), 1'b1, 1'b0);
      id_ir = rtype(8,8,9,'h20);
      #3;
      chk($sformatf("sat%0d stall", i), 32'(stall), 1);
      @(posedge clk); #1;
      if (i == 1) chk("sat s_stall_cnt=2", 32'(s_stall_cnt), 2);
    end
    chk("sat stall_cnt", 32'(stall_cnt), 5);
    chk("sat s_stall_cnt", 32'(s_stall_cnt), 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
    $finish;
  end

endmodule
